// File: rtl/mandel_pixel_engine_if.sv
// Valid/ready bundle between the pixel scanner, the Mandelbrot/Julia engine and the colour map.
// The engine is the slave: it consumes points and produces iteration results.
interface mandel_pixel_engine_if #(
  parameter int BITS      = 18,
  parameter int ITER_BITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [BITS-1:0] point_x;
  logic signed [BITS-1:0] point_y;
  logic                  julia;
  logic signed [BITS-1:0] jc_x;
  logic signed [BITS-1:0] jc_y;
  logic [ITER_BITS-1:0]  max_iter;
  logic                  out_valid;
  logic                  out_ready;
  logic [ITER_BITS-1:0]  iter_count;
  logic                  escaped;
  logic signed [BITS-1:0] z_x;
  logic signed [BITS-1:0] z_y;

  modport master (
    output in_valid, point_x, point_y, julia, jc_x, jc_y, max_iter, out_ready,
    input  in_ready, out_valid, iter_count, escaped, z_x, z_y
  );

  modport slave (
    input  in_valid, point_x, point_y, julia, jc_x, jc_y, max_iter, out_ready,
    output in_ready, out_valid, iter_count, escaped, z_x, z_y
  );
endinterface

// File: rtl/mandel_pixel_engine.sv
// Iterative single-pixel Mandelbrot/Julia engine: one z <= z^2 + c step per clock until
// |z|^2 > 4 or the per-point iteration limit, then presents count, escape flag and final z.
module mandel_pixel_engine #(
  parameter int BITS      = 18,
  parameter int ITER_BITS = 8
) (
  input logic              clk,
  input logic              rst,
  mandel_pixel_engine_if.slave bus
);

  localparam int F  = BITS - 3;
  localparam int PW = 2 * BITS;
  // Wide enough that 2*x*y at x=y=-4 plus cy cannot wrap before saturation.
  localparam int SW = BITS + 4;

  localparam logic signed [PW:0]   FOUR   = (PW+1)'(64'sd1 <<< (2*F + 2));
  localparam logic signed [SW-1:0] SAT_HI = SW'((64'sd1 <<< (BITS-1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(64'sd1 <<< (BITS-1)));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic signed [BITS-1:0] zx, zy, cx, cy;
  logic [ITER_BITS-1:0]   n, limit;
  logic [ITER_BITS-1:0]   iter_count_r;
  logic                   escaped_r;
  logic signed [BITS-1:0] zout_x, zout_y;

  logic signed [PW-1:0]   xx, yy, xy;
  logic signed [PW:0]     mag, diff;
  logic signed [SW-1:0]   xn_wide, yn_wide;
  logic signed [BITS-1:0] xn, yn;
  logic                   escape, at_limit, accept;

  function automatic logic signed [BITS-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI) return BITS'(SAT_HI);
    if (v < SAT_LO) return BITS'(SAT_LO);
    return BITS'(v);
  endfunction

  // Exact products; arithmetic right shifts give floor of the scaled results.
  assign xx      = PW'(zx) * PW'(zx);
  assign yy      = PW'(zy) * PW'(zy);
  assign xy      = PW'(zx) * PW'(zy);
  assign mag     = (PW+1)'(xx) + (PW+1)'(yy);
  assign diff    = (PW+1)'(xx) - (PW+1)'(yy);
  assign xn_wide = SW'(diff >>> F) + SW'(cx);
  assign yn_wide = SW'(xy >>> (F-1)) + SW'(cy);
  assign xn      = sat(xn_wide);
  assign yn      = sat(yn_wide);

  assign escape   = (mag > FOUR);
  assign at_limit = (n == limit);

  assign bus.in_ready   = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.iter_count = iter_count_r;
  assign bus.escaped    = escaped_r;
  assign bus.z_x        = zout_x;
  assign bus.z_y        = zout_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A point accepted in DONE (result handed off on the same edge) goes straight back to RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (escape || at_limit) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = RUN;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zx           <= '0;
      zy           <= '0;
      cx           <= '0;
      cy           <= '0;
      n            <= '0;
      limit        <= '0;
      iter_count_r <= '0;
      escaped_r    <= 1'b0;
      zout_x       <= '0;
      zout_y       <= '0;
    end else if (accept) begin
      cx    <= bus.julia ? bus.jc_x : bus.point_x;
      cy    <= bus.julia ? bus.jc_y : bus.point_y;
      zx    <= bus.julia ? bus.point_x : '0;
      zy    <= bus.julia ? bus.point_y : '0;
      n     <= '0;
      limit <= bus.max_iter;
    end else if (state == RUN) begin
      if (escape || at_limit) begin
        escaped_r    <= escape;
        iter_count_r <= n;
        zout_x       <= zx;
        zout_y       <= zy;
      end else begin
        zx <= xn;
        zy <= yn;
        n  <= n + ITER_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Self-checking bench for mandel_pixel_engine: directed points, randomized points against an
// arithmetic reference model, handshake stalls, back-to-back accept and mid-run reset.
module tb_mandel_pixel_engine;

  localparam int BITS      = 18;
  localparam int ITER_BITS = 8;
  localparam int F         = BITS - 3;
  localparam longint ONE   = 64'sd1 <<< F;
  localparam longint MAXV  = (64'sd1 <<< (BITS-1)) - 1;
  localparam longint MINV  = -(64'sd1 <<< (BITS-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int     got_it;
  bit     got_esc;
  longint got_zx, got_zy;
  int     got_lat;
  bit     got_to;

  mandel_pixel_engine_if #(.BITS(BITS), .ITER_BITS(ITER_BITS)) bus();

  mandel_pixel_engine #(.BITS(BITS), .ITER_BITS(ITER_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference: iterate the complex recurrence on integers scaled by 2^F.
  task automatic model(input longint px, input longint py, input bit jul, input longint jx,
                       input longint jy, input int lim, output int it, output bit esc,
                       output longint zx, output longint zy);
    longint cxm, cym, nx;
    bit     fin;
    cxm = jul ? jx : px;
    cym = jul ? jy : py;
    zx  = jul ? px : 0;
    zy  = jul ? py : 0;
    it  = 0;
    esc = 0;
    fin = 0;
    while (!fin) begin
      if (zx*zx + zy*zy > 4*ONE*ONE) begin
        esc = 1;
        fin = 1;
      end else if (it == lim) begin
        fin = 1;
      end else begin
        nx = clampv(fdiv(zx*zx - zy*zy, ONE) + cxm);
        zy = clampv(fdiv(2*zx*zy, ONE) + cym);
        zx = nx;
        it++;
      end
    end
  endtask

  task automatic drive_point(input longint px, input longint py, input bit jul,
                             input longint jx, input longint jy, input int mi);
    bus.point_x  = px[BITS-1:0];
    bus.point_y  = py[BITS-1:0];
    bus.julia    = jul;
    bus.jc_x     = jx[BITS-1:0];
    bus.jc_y     = jy[BITS-1:0];
    bus.max_iter = mi[ITER_BITS-1:0];
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_result();
    got_lat = 0;
    got_to  = 1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      got_lat++;
      if (bus.out_valid) begin
        got_to = 0;
        break;
      end
    end
    got_it  = int'(bus.iter_count);
    got_esc = bus.escaped;
    got_zx  = bus.z_x;
    got_zy  = bus.z_y;
  endtask

  task automatic accept_point(input longint px, input longint py, input bit jul,
                              input longint jx, input longint jy, input int mi);
    drive_point(px, py, jul, jx, jy, mi);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result();
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic longint rand_coord(input bit wide);
    if (wide) return longint'($urandom_range(0, (1 << BITS) - 1)) - (64'sd1 <<< (BITS-1));
    return longint'($urandom_range(0, 5*ONE)) - 3*ONE;
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.point_x   = '0;
    bus.point_y   = '0;
    bus.julia     = 1'b0;
    bus.jc_x      = '0;
    bus.jc_y      = '0;
    bus.max_iter  = '0;
    rst = 1'b1;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.escaped !== 1'b0) begin errors++; $display("[TB] FAIL reset_escaped got=%b exp=0", bus.escaped); end
    checks++; if (bus.iter_count !== '0) begin errors++; $display("[TB] FAIL reset_iter_count got=%0d exp=0", bus.iter_count); end
    checks++; if ({bus.z_x, bus.z_y} !== '0) begin errors++; $display("[TB] FAIL reset_z got=%0d,%0d exp=0,0", bus.z_x, bus.z_y); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    longint px, py; bit jul; longint jx, jy; int mi;
    int it; bit esc; longint zx, zy;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    v[0] = '{0,      0, 0, 0, 0,   20,  20, 0, 0,    0};
    v[1] = '{2*ONE,  0, 0, 0, 0,   50,  2,  1, MAXV, 0};
    v[2] = '{-2*ONE, 0, 0, 0, 0,   30,  30, 0, 2*ONE, 0};
    v[3] = '{0,      0, 1, 0, ONE, 10,  10, 0, -ONE, ONE};
    v[4] = '{3*ONE,  0, 1, 0, 0,   5,   0,  1, 3*ONE, 0};
    v[5] = '{ONE,    0, 0, 0, 0,   0,   0,  0, 0,    0};
    v[6] = '{0,      0, 0, 0, 0,   255, 255, 0, 0,   0};
    for (int i = 0; i < 7; i++) begin
      accept_point(v[i].px, v[i].py, v[i].jul, v[i].jx, v[i].jy, v[i].mi);
      checks++; if (got_to) begin errors++; $display("[TB] FAIL dir%0d_timeout got=no out_valid exp=out_valid", i); end
      checks++; if (got_it != v[i].it) begin errors++; $display("[TB] FAIL dir%0d_iter got=%0d exp=%0d", i, got_it, v[i].it); end
      checks++; if (got_esc != v[i].esc) begin errors++; $display("[TB] FAIL dir%0d_escaped got=%0d exp=%0d", i, got_esc, v[i].esc); end
      checks++; if (got_zx != v[i].zx || got_zy != v[i].zy) begin errors++; $display("[TB] FAIL dir%0d_z got=%0d,%0d exp=%0d,%0d", i, got_zx, got_zy, v[i].zx, v[i].zy); end
      checks++; if (got_lat != v[i].it + 1) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, got_lat, v[i].it + 1); end
      release_result();
    end
  endtask

  task automatic test_random();
    int     it;
    bit     esc, jul;
    longint ex, ey, px, py, jx, jy;
    int     mi;
    for (int i = 0; i < 40; i++) begin
      jul = 1'($urandom_range(0, 1));
      px  = rand_coord($urandom_range(0, 7) == 0);
      py  = rand_coord($urandom_range(0, 7) == 0);
      jx  = longint'($urandom_range(0, 2*ONE)) - ONE;
      jy  = longint'($urandom_range(0, 2*ONE)) - ONE;
      mi  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      model(px, py, jul, jx, jy, mi, it, esc, ex, ey);
      accept_point(px, py, jul, jx, jy, mi);
      checks++; if (got_to) begin errors++; $display("[TB] FAIL rnd%0d_timeout got=no out_valid exp=out_valid", i); end
      checks++; if (got_it != it) begin errors++; $display("[TB] FAIL rnd%0d_iter got=%0d exp=%0d", i, got_it, it); end
      checks++; if (got_esc != esc) begin errors++; $display("[TB] FAIL rnd%0d_escaped got=%0d exp=%0d", i, got_esc, esc); end
      checks++; if (got_zx != ex || got_zy != ey) begin errors++; $display("[TB] FAIL rnd%0d_z got=%0d,%0d exp=%0d,%0d", i, got_zx, got_zy, ex, ey); end
      checks++; if (got_lat != it + 1) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", i, got_lat, it + 1); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_result();
    end
  endtask

  // Stall in DONE, then consume and accept the next point on the same edge.
  task automatic test_back_to_back();
    int     it;
    bit     esc;
    longint ex, ey;
    int     h_it;
    bit     h_esc;
    longint h_zx, h_zy;
    model(-ONE, 0, 0, 0, 0, 8, it, esc, ex, ey);
    accept_point(-ONE, 0, 0, 0, 0, 8);
    checks++; if (got_to || got_it != it || got_zx != ex || got_zy != ey) begin errors++; $display("[TB] FAIL hs_first got=%0d,%0d,%0d exp=%0d,%0d,%0d", got_it, got_zx, got_zy, it, ex, ey); end
    h_it = got_it; h_esc = got_esc; h_zx = got_zx; h_zy = got_zy;
    for (int c = 0; c < 10; c++) begin
      drive_point(3*ONE, ONE, 1, ONE, ONE, 1);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || int'(bus.iter_count) != h_it ||
          bus.escaped !== h_esc || longint'(bus.z_x) != h_zx || longint'(bus.z_y) != h_zy) begin
        errors++;
        $display("[TB] FAIL hs_hold%0d got=v%b r%b it%0d z%0d,%0d exp=v1 r0 it%0d z%0d,%0d",
                 c, bus.out_valid, bus.in_ready, bus.iter_count, bus.z_x, bus.z_y, h_it, h_zx, h_zy);
      end
    end
    model(ONE/4, ONE/2, 0, 0, 0, 12, it, esc, ex, ey);
    drive_point(ONE/4, ONE/2, 0, 0, 0, 12);
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_out_valid_drop got=%b exp=0", bus.out_valid); end
    drive_point(-3*ONE, 2*ONE, 1, ONE, -ONE, 200);
    wait_result();
    bus.in_valid = 1'b0;
    checks++; if (got_to) begin errors++; $display("[TB] FAIL b2b_timeout got=no out_valid exp=out_valid"); end
    checks++; if (got_it != it || got_esc != esc) begin errors++; $display("[TB] FAIL b2b_iter got=%0d/%0d exp=%0d/%0d", got_it, got_esc, it, esc); end
    checks++; if (got_zx != ex || got_zy != ey) begin errors++; $display("[TB] FAIL b2b_z got=%0d,%0d exp=%0d,%0d", got_zx, got_zy, ex, ey); end
    checks++; if (got_lat != it + 1) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", got_lat, it + 1); end
    release_result();
  endtask

  task automatic test_reset_midrun();
    int     it;
    bit     esc;
    longint ex, ey;
    drive_point(0, 0, 0, 0, 0, 200);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.iter_count !== '0 || bus.escaped !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result got=%0d/%b exp=0/0", bus.iter_count, bus.escaped); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model(-ONE/2, ONE/2, 0, 0, 0, 25, it, esc, ex, ey);
    accept_point(-ONE/2, ONE/2, 0, 0, 0, 25);
    checks++; if (got_to || got_it != it || got_esc != esc) begin errors++; $display("[TB] FAIL midrst_next_iter got=%0d/%0d exp=%0d/%0d", got_it, got_esc, it, esc); end
    checks++; if (got_zx != ex || got_zy != ey) begin errors++; $display("[TB] FAIL midrst_next_z got=%0d,%0d exp=%0d,%0d", got_zx, got_zy, ex, ey); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
